wb_scene_memory_slave: RTL

//  Wishbone slave responder on the far end of the THEIA core's wishbone master port.

---
 rtl/wb_scene_memory_slave_if.sv | 35 +++
 rtl/wb_scene_memory_slave.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/wb_scene_memory_slave_if.sv
// Wishbone bus bundle between the THEIA master port and the scene memory slave.
// Optional ERR_O line is present only when WB_SCENE_SLAVE_ERR_EN is defined.
interface wb_scene_memory_slave_if #(
  parameter int DW = 32,
  parameter int AW = 32
) ();
  logic          CYC_I;
  logic          STB_I;
  logic          WE_I;
  logic [AW-1:0] ADR_I;
  logic [DW-1:0] DAT_I;
  logic [1:0]    TGA_I;
  logic [1:0]    TGC_I;
  logic [DW-1:0] DAT_O;
  logic          ACK_O;
`ifdef WB_SCENE_SLAVE_ERR_EN
  logic          ERR_O;
`endif

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, TGA_I, TGC_I,
    output DAT_O, ACK_O
`ifdef WB_SCENE_SLAVE_ERR_EN
    , output ERR_O
`endif
  );

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, DAT_I, TGA_I, TGC_I,
    input  DAT_O, ACK_O
`ifdef WB_SCENE_SLAVE_ERR_EN
    , input ERR_O
`endif
  );
endinterface

// File: rtl/wb_scene_memory_slave.sv
// Wishbone slave behind the THEIA master port: geometry/texture banks with a
// host preload port, programmable wait states and pixel write-back strobe.
// Optional feature macro: WB_SCENE_SLAVE_ERR_EN (out-of-range reads answer ERR_O).
// Bank depths are expected to be powers of two; the low address bits index a bank.
module wb_scene_memory_slave #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int GEO_DEPTH   = 1024,
  parameter int TEX_DEPTH   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  wb_scene_memory_slave_if.slave  wb,
  output logic                    oPixelValid,
  output logic [AW-1:0]           oPixelAdr,
  output logic [DW-1:0]           oPixelDat,
  output logic [1:0]              oPixelTag,
  input  logic                    iHostWE,
  input  logic                    iHostBank,
  input  logic [AW-1:0]           iHostAdr,
  input  logic [DW-1:0]           iHostDat
);
  localparam int GA = $clog2(GEO_DEPTH);
  localparam int TA = $clog2(TEX_DEPTH);
  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} stateT;

  stateT         state;
  logic [CW-1:0] cnt;
  logic          weLatch;
  logic [AW-1:0] adrLatch;
  logic [DW-1:0] datLatch;
  logic [1:0]    tgaLatch;
  logic [1:0]    tgcLatch;
  logic          ackReg;
  logic          ackReadReg;
  logic          texSelReg;
`ifdef WB_SCENE_SLAVE_ERR_EN
  logic          errReg;
`endif

  logic [DW-1:0] geoMem [GEO_DEPTH];
  logic [DW-1:0] texMem [TEX_DEPTH];
  logic [DW-1:0] geoQ;
  logic [DW-1:0] texQ;

  logic          request;
  logic          goAck;
  logic          curWe;
  logic [AW-1:0] curAdr;
  logic [DW-1:0] curDat;
  logic [1:0]    curTga;
  logic [1:0]    curTgc;
  logic          curTex;
  logic          curBad;
  logic          unusedHost;

  assign request = wb.CYC_I & wb.STB_I;

  // With zero wait states the request goes straight to ACK, so the live bus
  // fields are used; otherwise the copies latched at accept are used.
  assign curWe  = (state == IDLE) ? wb.WE_I  : weLatch;
  assign curAdr = (state == IDLE) ? wb.ADR_I : adrLatch;
  assign curDat = (state == IDLE) ? wb.DAT_I : datLatch;
  assign curTga = (state == IDLE) ? wb.TGA_I : tgaLatch;
  assign curTgc = (state == IDLE) ? wb.TGC_I : tgcLatch;
  assign curTex = (curTga == 2'b01);

`ifdef WB_SCENE_SLAVE_ERR_EN
  assign curBad = !curWe && (curTex ? (curAdr >= AW'(TEX_DEPTH)) : (curAdr >= AW'(GEO_DEPTH)));
`else
  assign curBad = 1'b0;
`endif

  // Host address bits above the bank index are don't-care.
  assign unusedHost = ^iHostAdr;

  // Detect the clock edge on which the FSM enters ACK; the bank read and all
  // response registers are loaded on that edge.
  always_comb begin
    goAck = 1'b0;
    case (state)
      IDLE:    goAck = request && (WAIT_STATES == 0);
      WAIT:    goAck = wb.CYC_I && (cnt == CW'(1));
      default: goAck = 1'b0;
    endcase
  end

  // Geometry bank: host write port, read-first bus read port (no reset).
  always_ff @(posedge CLK_I) begin
    if (iHostWE && !iHostBank) geoMem[iHostAdr[GA-1:0]] <= iHostDat;
    if (goAck && !curTex)      geoQ <= geoMem[curAdr[GA-1:0]];
  end

  // Texture bank: host write port, read-first bus read port (no reset).
  always_ff @(posedge CLK_I) begin
    if (iHostWE && iHostBank) texMem[iHostAdr[TA-1:0]] <= iHostDat;
    if (goAck && curTex)      texQ <= texMem[curAdr[TA-1:0]];
  end

  // Transfer FSM with its registered acknowledge and pixel strobe outputs.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state       <= IDLE;
      cnt         <= '0;
      weLatch     <= 1'b0;
      adrLatch    <= '0;
      datLatch    <= '0;
      tgaLatch    <= 2'b00;
      tgcLatch    <= 2'b00;
      ackReg      <= 1'b0;
      ackReadReg  <= 1'b0;
      texSelReg   <= 1'b0;
`ifdef WB_SCENE_SLAVE_ERR_EN
      errReg      <= 1'b0;
`endif
      oPixelValid <= 1'b0;
      oPixelAdr   <= '0;
      oPixelDat   <= '0;
      oPixelTag   <= 2'b00;
    end else begin
      ackReg      <= goAck && !curBad;
      ackReadReg  <= goAck && !curWe && !curBad;
`ifdef WB_SCENE_SLAVE_ERR_EN
      errReg      <= goAck && curBad;
`endif
      oPixelValid <= goAck && curWe;
      if (goAck) texSelReg <= curTex;
      if (goAck && curWe) begin
        oPixelAdr <= curAdr;
        oPixelDat <= curDat;
        oPixelTag <= curTgc;
      end

      case (state)
        IDLE: begin
          if (request) begin
            weLatch  <= wb.WE_I;
            adrLatch <= wb.ADR_I;
            datLatch <= wb.DAT_I;
            tgaLatch <= wb.TGA_I;
            tgcLatch <= wb.TGC_I;
            cnt      <= CW'(WAIT_STATES);
            state    <= (WAIT_STATES == 0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          // A dropped bus cycle abandons the transfer before any response.
          if (!wb.CYC_I) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= ACK;
          end
        end
        ACK: begin
          state <= HOLD;
        end
        default: begin
          // A strobe still held after ACK must not produce a second ACK.
          if (!wb.STB_I || !wb.CYC_I) state <= IDLE;
        end
      endcase
    end
  end

  assign wb.ACK_O = ackReg;
  assign wb.DAT_O = ackReadReg ? (texSelReg ? texQ : geoQ) : '0;
`ifdef WB_SCENE_SLAVE_ERR_EN
  assign wb.ERR_O = errReg;
`endif
endmodule
